// File: rtl/maccum_lane.sv
// maccum_lane: time-multiplexed fully-connected MAC stage.
// Consumes NL inputs per beat over NP/NL beats for NC neurons in parallel.
// Products are Q(WD-1) scaled by an arithmetic right shift (floor).
// Optional build macro: MACCUM_RELU_EN clamps negative neuron sums to zero.
module maccum_lane #(
  parameter int NP = 4,
  parameter int NC = 4,
  parameter int WD = 4,
  parameter int NL = 2,
  localparam int WO = WD + 2 + $clog2(NP),
  localparam int DW = NP*WD + NP*NC*WD + NC*WD
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iValid_AS,
  output logic              oReady_AS,
  input  logic [DW-1:0]     iData_AS,
  output logic              oValid_BS,
  input  logic              iReady_BS,
  output logic [NC*WO-1:0]  oData_BS
);

  localparam int NB = NP / NL;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int XW = NP * WD;
  localparam int OW = NP*WD + NP*NC*WD;
  localparam logic [BW-1:0] LAST = BW'(NB - 1);

  typedef enum logic [1:0] {IDLE, ACC, OUT} tState;

  tState stateReg, stateNext;
  logic [OW-1:0]          opReg;
  logic [BW-1:0]          beatReg;
  logic signed [WO-1:0]   accReg [NC];
  logic signed [WO-1:0]   accSum [NC];
  logic signed [WO-1:0]   resVal [NC];
  logic [NC*WO-1:0]       dataReg;
  logic signed [WD-1:0]   xOp [NP];
  logic signed [WD-1:0]   wOp [NC][NP];
  logic                   accept;
  logic                   lastBeat;

  // Full-precision product, then drop WD-1 fraction bits (floor toward -inf).
  function automatic logic signed [WD:0] scaleProd(input logic signed [WD-1:0] a,
                                                   input logic signed [WD-1:0] b);
    logic signed [2*WD-1:0] p;
    p = (2*WD)'(a) * (2*WD)'(b);
    return p[2*WD-1:WD-1];
  endfunction

  // Only x and w are kept; biases go straight into the accumulators on accept.
  genvar gi, gj;
  generate
    for (gi = 0; gi < NP; gi++) begin : gX
      assign xOp[gi] = opReg[gi*WD +: WD];
    end
    for (gi = 0; gi < NC; gi++) begin : gWRow
      for (gj = 0; gj < NP; gj++) begin : gWCol
        assign wOp[gi][gj] = opReg[XW + (gi*NP + gj)*WD +: WD];
      end
    end
  endgenerate

  // Per-neuron lane products for the current beat and the running sum.
  generate
    for (gi = 0; gi < NC; gi++) begin : gNeuron
      logic signed [WD:0]   laneTerm [NL];
      logic signed [WO-1:0] sumVal;
      for (gj = 0; gj < NL; gj++) begin : gLane
        assign laneTerm[gj] = scaleProd(xOp[int'(beatReg)*NL + gj],
                                        wOp[gi][int'(beatReg)*NL + gj]);
      end
      // Add this beat's sign-extended terms to the accumulator.
      always_comb begin
        sumVal = accReg[gi];
        for (int l = 0; l < NL; l++) begin
          sumVal = sumVal + WO'(laneTerm[l]);
        end
      end
      assign accSum[gi] = sumVal;
`ifdef MACCUM_RELU_EN
      assign resVal[gi] = sumVal[WO-1] ? '0 : sumVal;
`else
      assign resVal[gi] = sumVal;
`endif
    end
  endgenerate

  assign accept   = (stateReg == IDLE) && iValid_AS;
  assign lastBeat = (stateReg == ACC) && (beatReg == LAST);

  // State register.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) stateReg <= IDLE;
    else       stateReg <= stateNext;
  end

  // Next-state and handshake outputs.
  always_comb begin
    stateNext = stateReg;
    oReady_AS = 1'b0;
    oValid_BS = 1'b0;
    unique case (stateReg)
      IDLE: begin
        oReady_AS = 1'b1;
        if (iValid_AS) stateNext = ACC;
      end
      ACC: begin
        if (beatReg == LAST) stateNext = OUT;
      end
      OUT: begin
        oValid_BS = 1'b1;
        if (iReady_BS) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Operand capture, beat counting, accumulation and result register.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      opReg   <= '0;
      beatReg <= '0;
      dataReg <= '0;
      for (int c = 0; c < NC; c++) accReg[c] <= '0;
    end else if (accept) begin
      opReg   <= iData_AS[OW-1:0];
      beatReg <= '0;
      for (int c = 0; c < NC; c++) begin
        accReg[c] <= WO'($signed(iData_AS[OW + c*WD +: WD]));
      end
    end else if (stateReg == ACC) begin
      beatReg <= lastBeat ? '0 : beatReg + BW'(1);
      for (int c = 0; c < NC; c++) accReg[c] <= accSum[c];
      if (lastBeat) begin
        for (int c = 0; c < NC; c++) dataReg[c*WO +: WO] <= resVal[c];
      end
    end
  end

  assign oData_BS = dataReg;

endmodule

// File: tb/tb_maccum_lane.sv
// Self-checking bench for maccum_lane (NP=4, NC=2, WD=4, NL=2).
// Honours MACCUM_RELU_EN in its expectations.
module tb_maccum_lane;

  localparam int NP = 4;
  localparam int NC = 2;
  localparam int WD = 4;
  localparam int NL = 2;
  localparam int WO = WD + 2 + $clog2(NP);
  localparam int DW = NP*WD + NP*NC*WD + NC*WD;

  logic              iCLK = 1'b0;
  logic              iRST;
  logic              iValid_AS;
  logic              oReady_AS;
  logic [DW-1:0]     iData_AS;
  logic              oValid_BS;
  logic              iReady_BS;
  logic [NC*WO-1:0]  oData_BS;

  int nChecks = 0;
  int nFails  = 0;

  int xs [NP];
  int ws [NC][NP];
  int bs [NC];

  typedef struct {
    int xv; int wv; int b0; int b1; int y0; int y1;
  } tVec;
  tVec tbl [5];

  maccum_lane #(.NP(NP), .NC(NC), .WD(WD), .NL(NL)) dut (
    .iCLK      (iCLK),
    .iRST      (iRST),
    .iValid_AS (iValid_AS),
    .oReady_AS (oReady_AS),
    .iData_AS  (iData_AS),
    .oValid_BS (oValid_BS),
    .iReady_BS (iReady_BS),
    .oData_BS  (oData_BS)
  );

  always #5 iCLK = ~iCLK;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    nChecks++;
    if (act !== 32'(exp)) begin
      nFails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d", name, $signed(act), act, exp);
    end
  endtask

  function automatic int relu(input int v);
`ifdef MACCUM_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  // Reference: y = b + sum floor(x*w / 2^(WD-1)), optionally clamped.
  function automatic int modelY(input int c);
    int s;
    s = bs[c];
    for (int i = 0; i < NP; i++) begin
      s += int'($floor(real'(xs[i] * ws[c][i]) / real'(1 << (WD-1))));
    end
    return relu(s);
  endfunction

  function automatic logic [DW-1:0] packOps();
    logic [DW-1:0] d;
    d = '0;
    for (int i = 0; i < NP; i++) d[i*WD +: WD] = WD'(xs[i]);
    for (int c = 0; c < NC; c++)
      for (int i = 0; i < NP; i++) d[NP*WD + (c*NP + i)*WD +: WD] = WD'(ws[c][i]);
    for (int c = 0; c < NC; c++) d[NP*WD + NP*NC*WD + c*WD +: WD] = WD'(bs[c]);
    return d;
  endfunction

  function automatic int yOut(input int c);
    return int'($signed(oData_BS[c*WO +: WO]));
  endfunction

  task automatic setUniform(input int xv, input int wv, input int b0, input int b1);
    for (int i = 0; i < NP; i++) begin
      xs[i] = xv;
      for (int c = 0; c < NC; c++) ws[c][i] = wv;
    end
    bs[0] = b0;
    bs[1] = b1;
  endtask

  task automatic setRandom();
    for (int i = 0; i < NP; i++) begin
      xs[i] = int'($urandom_range(0, 15)) - 8;
      for (int c = 0; c < NC; c++) ws[c][i] = int'($urandom_range(0, 15)) - 8;
    end
    for (int c = 0; c < NC; c++) bs[c] = int'($urandom_range(0, 15)) - 8;
  endtask

  // Present the packed operands in IDLE and return #1 after the accept edge.
  task automatic acceptBundle(input string tag);
    @(negedge iCLK);
    iValid_AS = 1'b1;
    iData_AS  = packOps();
    check({tag, " ready"}, 32'(oReady_AS), 1);
    @(posedge iCLK);
    #1;
    iValid_AS = 1'b0;
  endtask

  // Count edges from accept to oValid_BS; optionally toss junk at the input meanwhile.
  task automatic waitResult(input string tag, input bit junk);
    int cyc;
    cyc = 0;
    while (!oValid_BS && cyc < 20) begin
      if (junk) begin
        iValid_AS = 1'($urandom);
        iData_AS  = DW'({$urandom, $urandom});
      end
      @(posedge iCLK);
      #1;
      cyc++;
    end
    iValid_AS = 1'b0;
    check({tag, " latency"}, 32'(cyc), NP/NL);
  endtask

  task automatic drainCheck(input string tag);
    @(posedge iCLK);
    #1;
    check({tag, " valid drop"}, 32'(oValid_BS), 0);
    check({tag, " ready back"}, 32'(oReady_AS), 1);
  endtask

  initial begin
    tbl[0] = '{xv:  4, wv:  4, b0:  0, b1:  0, y0:  8, y1:  8};
    tbl[1] = '{xv: -8, wv: -8, b0:  7, b1: -8, y0: 39, y1: 24};
    tbl[2] = '{xv:  4, wv: -4, b0: -1, b1: -1, y0: -9, y1: -9};
    tbl[3] = '{xv: -1, wv:  1, b0:  0, b1:  0, y0: -4, y1: -4};
    tbl[4] = '{xv:  1, wv:  1, b0:  0, b1:  0, y0:  0, y1:  0};

    iRST      = 1'b0;
    iValid_AS = 1'b0;
    iReady_BS = 1'b1;
    iData_AS  = '0;
    repeat (2) @(posedge iCLK);
    #1;
    check("reset ready", 32'(oReady_AS), 1);
    check("reset valid", 32'(oValid_BS), 0);
    check("reset data", 32'(oData_BS), 0);
    @(negedge iCLK);
    iRST = 1'b1;

    // Directed vectors.
    for (int t = 0; t < 5; t++) begin
      string tag;
      tag = $sformatf("vec%0d", t);
      setUniform(tbl[t].xv, tbl[t].wv, tbl[t].b0, tbl[t].b1);
      acceptBundle(tag);
      waitResult(tag, 1'b0);
      check({tag, " y0"}, 32'(yOut(0)), relu(tbl[t].y0));
      check({tag, " y1"}, 32'(yOut(1)), relu(tbl[t].y1));
      drainCheck(tag);
      $display("%s x=%0d w=%0d b=%0d/%0d -> y0=%0d y1=%0d", tag, tbl[t].xv, tbl[t].wv,
               tbl[t].b0, tbl[t].b1, yOut(0), yOut(1));
    end

    // Randomised bundles with junk on the input during ACC and random stalls.
    for (int t = 0; t < 30; t++) begin
      string tag;
      int stall;
      tag = $sformatf("rnd%0d", t);
      setRandom();
      acceptBundle(tag);
      waitResult(tag, 1'b1);
      check({tag, " y0"}, 32'(yOut(0)), modelY(0));
      check({tag, " y1"}, 32'(yOut(1)), modelY(1));
      $display("%s y0=%0d/%0d y1=%0d/%0d", tag, yOut(0), modelY(0), yOut(1), modelY(1));
      stall = int'($urandom_range(0, 2));
      iReady_BS = 1'b0;
      for (int k = 0; k < stall; k++) begin
        @(posedge iCLK);
        #1;
        check({tag, " stall valid"}, 32'(oValid_BS), 1);
      end
      iReady_BS = 1'b1;
      drainCheck(tag);
    end

    // Backpressure: hold OUT for 5 cycles while a second bundle waits.
    setUniform(4, 4, 0, 0);
    iReady_BS = 1'b0;
    acceptBundle("bpA");
    waitResult("bpA", 1'b0);
    setUniform(-8, -8, 7, -8);
    iValid_AS = 1'b1;
    iData_AS  = packOps();
    for (int k = 0; k < 5; k++) begin
      @(posedge iCLK);
      #1;
      check($sformatf("bp hold%0d y0", k), 32'(yOut(0)), 8);
      check($sformatf("bp hold%0d ready", k), 32'(oReady_AS), 0);
      check($sformatf("bp hold%0d valid", k), 32'(oValid_BS), 1);
    end
    iReady_BS = 1'b1;
    @(posedge iCLK);
    #1;
    check("bp release valid", 32'(oValid_BS), 0);
    check("bp release ready", 32'(oReady_AS), 1);
    @(posedge iCLK);
    #1;
    check("bpB accepted", 32'(oReady_AS), 0);
    iValid_AS = 1'b0;
    waitResult("bpB", 1'b0);
    check("bpB y0", 32'(yOut(0)), modelY(0));
    check("bpB y1", 32'(yOut(1)), modelY(1));
    $display("backpressure second bundle y0=%0d y1=%0d", yOut(0), yOut(1));
    drainCheck("bpB");

    // Reset during the second ACC beat, then a clean bundle.
    setUniform(7, 7, 7, 7);
    acceptBundle("rstA");
    @(posedge iCLK);
    #1;
    iRST = 1'b0;
    #1;
    check("midrst valid", 32'(oValid_BS), 0);
    check("midrst ready", 32'(oReady_AS), 1);
    check("midrst data", 32'(oData_BS), 0);
    @(negedge iCLK);
    @(negedge iCLK);
    iRST = 1'b1;
    repeat (3) @(posedge iCLK);
    #1;
    check("postrst no pulse", 32'(oValid_BS), 0);
    setUniform(1, -4, 3, 5);
    acceptBundle("rstB");
    waitResult("rstB", 1'b0);
    check("rstB y0", 32'(yOut(0)), modelY(0));
    check("rstB y1", 32'(yOut(1)), modelY(1));
    $display("post-reset bundle y0=%0d y1=%0d", yOut(0), yOut(1));
    drainCheck("rstB");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/maccum_lane.md
Name: maccum_lane

Overview:
- Time-multiplexed multiply-accumulate layer stage: fully-connected neuron group computing NC outputs from NP inputs, NP×NC weights and NC biases, all signed fixed-point.
- Parametrised successor of the fully-parallel accumulator: processes NL inputs per cycle over NP/NL beats, so area trades against latency.
- Adds explicit fixed-point scaling, bias-aware output width and an optional ReLU.
- Sits between a layer's operand packer and the next layer's input on valid/ready streams.

Parameters:
- NP, 4, number of inputs per neuron.
- NC, 4, number of neurons (outputs).
- WD, 4, operand width; signed Q(WD-1) for inputs, weights and biases.
- NL, 2, inputs consumed per beat; must divide NP; NL=NP gives a single beat.
- WO, WD+2+$clog2(NP), output width per neuron (derived, not overridden).

Ports:
- iCLK  in  1  clock, rising edge.
- iRST  in  1  reset, asynchronous, active-low.
- iValid_AS  in  1  operand bundle valid.
- oReady_AS  out  1  ready to accept a bundle.
- iData_AS  in  NP*WD+NP*NC*WD+NC*WD  packed operands:
  - x[i] at bits i*WD.
  - w[c][i] at NP*WD+(c*NP+i)*WD.
  - b[c] at NP*WD+NP*NC*WD+c*WD.
- oValid_BS  out  1  result valid.
- iReady_BS  in  1  downstream ready.
- oData_BS  out  NC*WO  y[c] at bits c*WO, signed.

Behaviour:
- Reset (iRST=0, async): state IDLE, oReady_AS=1, oValid_BS=0, oData_BS=0, beat counter 0, accumulators 0.
- FSM states IDLE, ACC, OUT.
  - IDLE: oReady_AS=1. On iValid_AS&oReady_AS, register the whole iData_AS, load acc[c] with sign-extended b[c], and set beat=0. Next state is ACC.
  - ACC: oReady_AS=0. Each cycle, for lanes l=0..NL-1 with i=beat*NL+l, form p=x[i]*w[c][i].
    - p is the 2WD-bit signed product, arithmetic-shifted right by WD-1 (floor toward -inf), giving WD+1 bits.
    - acc[c] += sign-extended p, for all c in parallel.
    - beat increments each cycle. After beat NP/NL-1, the final sums are registered to oData_BS, oValid_BS=1, and the next state is OUT.
  - OUT: oValid_BS=1 and oData_BS hold stable until iValid is consumed by iReady_BS=1. On that handshake edge: oValid_BS=0, next state IDLE, oReady_AS=1 the following cycle.
- Latency: oValid_BS rises NP/NL cycles after the accept edge.
  - Minimum bundle period is NP/NL+2 cycles.
  - No input is accepted in ACC or OUT.
- Width: WO covers NP terms of WD+1 bits plus the bias; no overflow is possible; no saturation.
- Boundary cases:
  - NL=NP: single ACC cycle.
  - iReady_BS held high on arrival: OUT lasts exactly 1 cycle.
  - iValid_AS high in ACC/OUT: ignored; the operand register is unchanged.
  - Reset mid-ACC or mid-OUT: immediate return to reset values; the partial result is discarded; no oValid_BS pulse.
  - iData_AS is not sampled except on the accept edge.

Optional Feature:
- MACCUM_RELU_EN defined: the value registered to oData_BS is max(acc[c],0) per neuron; negative sums output 0.
- MACCUM_RELU_EN undefined: raw signed sums are output.
- Timing and handshake are identical in both builds.

Test Plan:
- NP=4,NC=2,WD=4,NL=2; all x=4, all w=4, b=0 → y0=y1=8 (0x08); oValid_BS rises 2 cycles after accept.
- x=-8, w=-8, b0=7, b1=-8 → y0=39 (0x27), y1=24 (0x18).
- x=4, w=-4, b=-1 → y=-9 (0xF7); with MACCUM_RELU_EN, y=0.
- Floor rounding: x=-1, w=1, b=0 → y=-4 (0xFC); x=1, w=1 → y=0.
- Backpressure: iReady_BS low 5 cycles in OUT → oData_BS stable, oReady_AS=0, second bundle ignored. Then iReady_BS=1 → IDLE; second bundle accepted next cycle.
- Reset asserted in the ACC beat 1 cycle → outputs at reset values within the cycle; a new bundle after release yields the correct result with no stale contribution.
